// File: rtl/dct_8_pkg.sv
// Shared constants and types for the 8-point DCT pipeline stages.
package dct_8_pkg;

  localparam int unsigned LANE_W    = 64;
  localparam int unsigned LANES     = 8;
  localparam int unsigned FRAC_BITS = 32;

  // cos(pi/4) in Q32.32
  localparam logic [LANE_W-1:0] C_COS4 = 64'h00000000B504F334;

  typedef logic signed [LANE_W-1:0] lane_t;

endpackage

// File: rtl/dct_8_pipe_slice.sv
// One valid/ready register slice: data loads only on load, valid tracks occupancy.
module dct_8_pipe_slice #(
  parameter int unsigned WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // Occupancy and data register; a load takes priority over a concurrent unload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (load) begin
        q <= d;
      end
      if (load) begin
        valid <= 1'b1;
      end else if (unload) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dct_8_stage_4_inner.sv
// DCT-8 stage 4: even/odd butterflies and cos(pi/4) scaling behind a two-deep
// elastic pipeline (S1 holds the input vector, S2 holds the result).
module dct_8_stage_4_inner #(
  parameter int unsigned       LANE_W    = dct_8_pkg::LANE_W,
  parameter int unsigned       LANES     = dct_8_pkg::LANES,
  parameter int unsigned       FRAC_BITS = dct_8_pkg::FRAC_BITS,
  parameter logic [LANE_W-1:0] C_COS4    = dct_8_pkg::C_COS4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANE_W*LANES-1:0] i_data_in,
  input  logic                    i_valid,
  output logic                    i_ready,
  output logic [LANE_W*LANES-1:0] o_data_out,
  output logic                    o_valid,
  input  logic                    o_ready
);

  import dct_8_pkg::*;

  localparam int unsigned W  = LANE_W * LANES;
  localparam int unsigned PW = 2 * LANE_W;
  localparam logic signed [LANE_W-1:0] C_S = C_COS4;

  logic         s1_v, s2_v;
  logic         s1_load, s2_load;
  logic [W-1:0] s1_q;
  logic [W-1:0] y_flat;

  logic signed [LANE_W-1:0] x [LANES];
  logic signed [LANE_W-1:0] y [LANES];
  logic signed [PW-1:0]     p5, p6;

  // Handshake: S2 refills from S1 when empty or draining; S1 accepts when it
  // is empty or being emptied into S2 this cycle. Ready is held low in reset.
  assign s2_load = s1_v && (!s2_v || o_ready);
  assign i_ready = !rst && (!s1_v || s2_load);
  assign s1_load = i_valid && i_ready;

  dct_8_pipe_slice #(.WIDTH(W)) u_s1 (
    .clk    (clk),
    .rst    (rst),
    .load   (s1_load),
    .unload (s2_load),
    .d      (i_data_in),
    .q      (s1_q),
    .valid  (s1_v)
  );

  dct_8_pipe_slice #(.WIDTH(W)) u_s2 (
    .clk    (clk),
    .rst    (rst),
    .load   (s2_load),
    .unload (o_ready),
    .d      (y_flat),
    .q      (o_data_out),
    .valid  (s2_v)
  );

  assign o_valid = s2_v;

  // Butterfly and scaling arithmetic on S1 contents; adds wrap, products are
  // full-width signed, arithmetically shifted, then truncated to a lane.
  always_comb begin
    y      = '{default: '0};
    y_flat = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      x[k] = s1_q[k*LANE_W +: LANE_W];
    end
    p5 = PW'(x[5]) * PW'(C_S);
    p6 = PW'(x[6]) * PW'(C_S);
    y[0] = x[0] + x[1];
    y[1] = x[0] - x[1];
    y[2] = x[2];
    y[3] = x[3];
    y[4] = x[4] + x[7];
    y[7] = x[4] - x[7];
    y[5] = LANE_W'(p5 >>> FRAC_BITS);
    y[6] = LANE_W'(p6 >>> FRAC_BITS);
    for (int unsigned k = 0; k < LANES; k++) begin
      y_flat[k*LANE_W +: LANE_W] = y[k];
    end
  end

endmodule

// File: tb/tb_dct_8_stage_4_inner.sv
// Self-checking bench for dct_8_stage_4_inner with a queue-based reference model.
module tb_dct_8_stage_4_inner;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] i_data_in;
  logic         i_valid;
  logic         i_ready;
  logic [511:0] o_data_out;
  logic         o_valid;
  logic         o_ready;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_acc  = 0;
  int iv_pct = 100;
  int or_pct = -1;   // -1: leave o_ready as set by the sequence

  logic [511:0] exp_q[$];
  logic [511:0] src[$];
  logic         held_v = 1'b0;
  logic [511:0] held_d;

  always #5 clk = ~clk;

  dct_8_stage_4_inner #(
    .LANE_W    (64),
    .LANES     (8),
    .FRAC_BITS (32),
    .C_COS4    (64'h00000000B504F334)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data_in  (i_data_in),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .o_data_out (o_data_out),
    .o_valid    (o_valid),
    .o_ready    (o_ready)
  );

  // floor(x * cos(pi/4)) with cos(pi/4) = 3037000500 / 2^32, wrapped to 64 bits
  function automatic logic [63:0] model_scale(input logic [63:0] x);
    logic signed [127:0] p, q, d;
    d = 128'sd4294967296;
    p = {{64{x[63]}}, x};
    p = p * 128'sd3037000500;
    q = p / d;
    if (p < 0 && (p % d) != 0) q = q - 1;
    return q[63:0];
  endfunction

  function automatic logic [511:0] model(input logic [511:0] v);
    logic [63:0] x [8];
    logic [63:0] y [8];
    logic [511:0] r;
    for (int i = 0; i < 8; i++) x[i] = v[i*64 +: 64];
    y[0] = x[0] + x[1];
    y[1] = x[0] - x[1];
    y[2] = x[2];
    y[3] = x[3];
    y[4] = x[4] + x[7];
    y[7] = x[4] - x[7];
    y[5] = model_scale(x[5]);
    y[6] = model_scale(x[6]);
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = y[i];
    return r;
  endfunction

  function automatic logic [511:0] pack8(input logic [63:0] a [8]);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = a[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Compare process: at each negedge decide which handshakes fire on the next edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held_v = 1'b0;
      chk("rst_outputs", {510'd0, i_ready, o_valid}, '0);
    end else begin
      if (held_v) begin
        chk("hold_valid", {511'd0, o_valid}, 512'd1);
        chk("hold_data", o_data_out, held_d);
      end
      if (o_valid && o_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output got=%h want=none", o_data_out);
        end else begin
          chk("stream", o_data_out, exp_q.pop_front());
        end
      end
      held_v = o_valid && !o_ready;
      held_d = o_data_out;
      if (i_valid && i_ready) exp_q.push_back(model(i_data_in));
    end
  end

  // Upstream driver: entered and left at posedge+1; holds a presented vector until taken.
  task automatic run_cycles(input int n);
    logic pend = 1'b0;
    logic acc;
    for (int c = 0; c < n; c++) begin
      if (or_pct >= 0) o_ready = ($urandom_range(99) < or_pct);
      if (src.size() != 0 && (pend || $urandom_range(99) < iv_pct)) begin
        i_valid   = 1'b1;
        i_data_in = src[0];
        pend      = 1'b1;
      end else begin
        i_valid   = 1'b0;
        i_data_in = rand_vec();
      end
      @(negedge clk);
      acc = i_valid && i_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        void'(src.pop_front());
        n_acc++;
        pend = 1'b0;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic directed(input string name, input logic [63:0] xa [8], input logic [63:0] ya [8]);
    src.push_back(pack8(xa));
    o_ready = 1'b1;
    run_cycles(1);
    chk({name, "_early"}, {511'd0, o_valid}, '0);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, {511'd0, o_valid}, 512'd1);
    chk(name, o_data_out, pack8(ya));
    run_cycles(2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] xa [8];
    logic [63:0] ya [8];
    int base;

    rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0; i_data_in = '0;
    #12;
    chk("reset_ready", {511'd0, i_ready}, '0);
    chk("reset_valid", {511'd0, o_valid}, '0);
    chk("reset_data", o_data_out, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {511'd0, i_ready}, 512'd1);

    // Pin the model itself with hand-computed values.
    chk("model_s5", {448'd0, model_scale(64'd5)}, 512'd3);
    chk("model_s1000", {448'd0, model_scale(64'd1000)}, 512'd707);
    chk("model_sm1000", {448'd0, model_scale(-64'sd1000)}, {448'd0, -64'sd708});

    xa = '{64'd0, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7};
    ya = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd3, 64'd11, 64'd3, 64'd4, -64'sd3};
    directed("basic", xa, ya);

    xa = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1000, -64'sd1000, 64'd0};
    ya = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd707, -64'sd708, 64'd0};
    directed("scale_sign", xa, ya);

    xa = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    ya = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFE, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    directed("wrap", xa, ya);

    // Back-pressure: only two vectors fit, output held stable.
    o_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 4; i++) src.push_back(rand_vec());
    run_cycles(6);
    chk("bp_accepts", 512'(n_acc - base), 512'd2);
    i_valid = 1'b1;
    #1;
    chk("bp_ready_low", {511'd0, i_ready}, '0);
    o_ready = 1'b1;
    run_cycles(8);
    chk("bp_all_in", 512'(n_acc - base), 512'd4);
    chk("bp_drained", 512'(exp_q.size()), '0);

    // Full rate.
    base = n_out;
    for (int i = 0; i < 100; i++) src.push_back(rand_vec());
    run_cycles(100);
    chk("full_rate_in", 512'(src.size()), '0);
    run_cycles(2);
    chk("full_rate_out", 512'(n_out - base), 512'd100);

    // Random valid/ready mix.
    iv_pct = 60;
    or_pct = 50;
    for (int i = 0; i < 60; i++) src.push_back(rand_vec());
    for (int c = 0; c < 600 && (src.size() != 0 || exp_q.size() != 0); c++) run_cycles(1);
    or_pct = -1;
    iv_pct = 100;
    o_ready = 1'b1;
    run_cycles(3);
    chk("random_drained", 512'(src.size() + exp_q.size()), '0);

    // Reset with both stages full.
    o_ready = 1'b0;
    for (int i = 0; i < 3; i++) src.push_back(rand_vec());
    run_cycles(4);
    chk("pre_reset_full", {511'd0, o_valid}, 512'd1);
    i_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {511'd0, o_valid}, '0);
    chk("async_rst_data", o_data_out, '0);
    chk("async_rst_ready", {511'd0, i_ready}, '0);
    i_valid = 1'b0;
    src.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    o_ready = 1'b1;
    base = n_out;
    @(posedge clk);
    #1;
    run_cycles(5);
    chk("no_stale_out", 512'(n_out - base), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
